gshare_predictor: RTL and testbench

Parametrised gshare direction predictor for the RV32I fetch stage. The table index is the PC word index XORed with a global history register (GHR). Each entry holds a tag, a valid bit and an N-bit saturating counter. The block has a 1-cycle lookup port toward fetch and a resolve/update port from execute, with GHR repair on mispredict.

---
 rtl/gshare_predictor_pkg.sv | 35 +++
 rtl/gshare_predictor_if.sv | 26 ++
 rtl/gshare_predictor_table.sv | 62 ++++++
 rtl/gshare_predictor.sv | 110 +++++++++++
 tb/tb_gshare_predictor.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared types, default geometry, counter constants and helpers for the gshare predictor.
package bp_pkg;

    localparam int unsigned DEF_INDEX_BITS   = 10;
    localparam int unsigned DEF_TAG_BITS     = 8;
    localparam int unsigned DEF_COUNTER_BITS = 2;
    localparam int unsigned DEF_GHR_BITS     = 8;

    localparam logic [DEF_COUNTER_BITS-1:0] WNT = DEF_COUNTER_BITS'((1 << (DEF_COUNTER_BITS - 1)) - 1);
    localparam logic [DEF_COUNTER_BITS-1:0] WT  = WNT + 1'b1;

    typedef enum logic {INIT, RUN} bp_state_t;

    typedef struct packed {
        logic                        valid;
        logic [DEF_TAG_BITS-1:0]     tag;
        logic [DEF_COUNTER_BITS-1:0] counter;
    } bp_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] c, input int unsigned bits);
        logic [31:0] max_v;
        max_v = (32'd1 << bits) - 32'd1;
        return (c == max_v) ? c : c + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] c);
        return (c == '0) ? c : c - 32'd1;
    endfunction

    function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr,
                                             input int unsigned index_bits);
        return ((pc >> 2) ^ ghr) & ((32'd1 << index_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Lookup and resolve/update bus between fetch/execute (master) and the predictor (slave).
interface gshare_predictor_if #(
    parameter int unsigned GHR_BITS = 8
);
    logic                pred_req_i;
    logic [31:0]         pred_pc_i;
    logic                pred_ready_o;
    logic                pred_valid_o;
    logic                pred_taken_o;
    logic [GHR_BITS-1:0] pred_ghr_o;
    logic                upd_valid_i;
    logic [31:0]         upd_pc_i;
    logic [GHR_BITS-1:0] upd_ghr_i;
    logic                upd_taken_i;
    logic                upd_mispredict_i;

    modport master (
        output pred_req_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_mispredict_i,
        input  pred_ready_o, pred_valid_o, pred_taken_o, pred_ghr_o
    );

    modport slave (
        input  pred_req_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_mispredict_i,
        output pred_ready_o, pred_valid_o, pred_taken_o, pred_ghr_o
    );
endinterface

// File: rtl/gshare_predictor_table.sv
// Predictor entry storage: two combinational read ports, one write port, and the init sweep.
module bp_table #(
    parameter int unsigned INDEX_BITS   = 10,
    parameter int unsigned TAG_BITS     = 8,
    parameter int unsigned COUNTER_BITS = 2,
    parameter logic [COUNTER_BITS-1:0] INIT_COUNTER = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] lk_idx,
    output logic                  lk_valid,
    output logic [TAG_BITS-1:0]   lk_tag,
    output logic [COUNTER_BITS-1:0] lk_counter,
    input  logic [INDEX_BITS-1:0] up_idx,
    output logic                  up_valid,
    output logic [TAG_BITS-1:0]   up_tag,
    output logic [COUNTER_BITS-1:0] up_counter,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [COUNTER_BITS-1:0] wr_counter,
    output logic                  sweep_last,
    output logic                  init_done
);
    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    typedef struct packed {
        logic                    valid;
        logic [TAG_BITS-1:0]     tag;
        logic [COUNTER_BITS-1:0] counter;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [INDEX_BITS-1:0] ptr;

    assign sweep_last = !init_done && (ptr == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            init_done <= 1'b0;
        end else if (!init_done) begin
            ptr <= ptr + 1'b1;
            if (ptr == '1) init_done <= 1'b1;
        end
    end

    // The sweep owns the write port until it completes; normal writes are only issued in RUN.
    always_ff @(posedge clk) begin
        if (!init_done) mem[ptr] <= '{valid: 1'b0, tag: '0, counter: INIT_COUNTER};
        else if (wr_en) mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, counter: wr_counter};
    end

    always_comb begin
        lk_valid   = mem[lk_idx].valid;
        lk_tag     = mem[lk_idx].tag;
        lk_counter = mem[lk_idx].counter;
        up_valid   = mem[up_idx].valid;
        up_tag     = mem[up_idx].tag;
        up_counter = mem[up_idx].counter;
    end
endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor top: lookup, speculative GHR, update and mispredict repair.
// Optional BP_STATS_EN adds lookup/mispredict counters.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS   = DEF_INDEX_BITS,
    parameter int unsigned TAG_BITS     = DEF_TAG_BITS,
    parameter int unsigned COUNTER_BITS = DEF_COUNTER_BITS,
    parameter int unsigned GHR_BITS     = DEF_GHR_BITS
) (
    input  logic clk,
    input  logic reset,
    gshare_predictor_if.slave bus,
`ifdef BP_STATS_EN
    output logic [31:0] stat_lookups_o,
    output logic [31:0] stat_mispred_o,
`endif
    output logic init_done_o
);
    localparam logic [COUNTER_BITS-1:0] CNT_WNT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_WT  = CNT_WNT + 1'b1;

    bp_state_t state, state_nxt;
    logic ready, sweep_last, accept, upd_en, repair, lk_taken, up_hit;
    logic [GHR_BITS-1:0]     ghr, pred_ghr_q;
    logic                    pred_valid_q, pred_taken_q;
    logic [INDEX_BITS-1:0]   lk_idx, up_idx;
    logic [TAG_BITS-1:0]     lk_tag_pc, up_tag_pc, lk_tag, up_tag;
    logic [COUNTER_BITS-1:0] lk_counter, up_counter, new_counter;
    logic                    lk_valid, up_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            INIT: if (sweep_last) state_nxt = RUN;
            RUN:  ready = 1'b1;
            default: state_nxt = INIT;
        endcase
    end

    assign lk_idx    = INDEX_BITS'(bp_index(bus.pred_pc_i, 32'(ghr), INDEX_BITS));
    assign up_idx    = INDEX_BITS'(bp_index(bus.upd_pc_i, 32'(bus.upd_ghr_i), INDEX_BITS));
    assign lk_tag_pc = bus.pred_pc_i[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign up_tag_pc = bus.upd_pc_i[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

    assign accept   = bus.pred_req_i && ready;
    assign upd_en   = bus.upd_valid_i && ready;
    assign repair   = upd_en && bus.upd_mispredict_i;
    assign lk_taken = lk_valid && (lk_tag == lk_tag_pc) && lk_counter[COUNTER_BITS-1];
    assign up_hit   = up_valid && (up_tag == up_tag_pc);

    always_comb begin
        new_counter = bus.upd_taken_i ? CNT_WT : CNT_WNT;
        if (up_hit)
            new_counter = bus.upd_taken_i ? COUNTER_BITS'(sat_inc(32'(up_counter), COUNTER_BITS))
                                          : COUNTER_BITS'(sat_dec(32'(up_counter)));
    end

    bp_table #(
        .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS),
        .COUNTER_BITS(COUNTER_BITS), .INIT_COUNTER(CNT_WNT)
    ) u_table (
        .clk(clk), .reset(reset),
        .lk_idx(lk_idx), .lk_valid(lk_valid), .lk_tag(lk_tag), .lk_counter(lk_counter),
        .up_idx(up_idx), .up_valid(up_valid), .up_tag(up_tag), .up_counter(up_counter),
        .wr_en(upd_en), .wr_idx(up_idx), .wr_tag(up_tag_pc), .wr_counter(new_counter),
        .sweep_last(sweep_last), .init_done(init_done_o)
    );

    // Repair overrides the speculative shift; the emitted prediction is left untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
            ghr          <= '0;
        end else begin
            pred_valid_q <= accept;
            if (accept) begin
                pred_taken_q <= lk_taken;
                pred_ghr_q   <= ghr;
            end
            if (repair)      ghr <= {bus.upd_ghr_i[GHR_BITS-2:0], bus.upd_taken_i};
            else if (accept) ghr <= {ghr[GHR_BITS-2:0], lk_taken};
        end
    end

    assign bus.pred_ready_o = ready;
    assign bus.pred_valid_o = pred_valid_q;
    assign bus.pred_taken_o = pred_taken_q;
    assign bus.pred_ghr_o   = pred_ghr_q;

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_lookups_o <= '0;
            stat_mispred_o <= '0;
        end else begin
            if (accept) stat_lookups_o <= stat_lookups_o + 32'd1;
            if (repair) stat_mispred_o <= stat_mispred_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor with hand-computed expectations.
module tb_gshare_predictor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_done;
    int   n_checks = 0;
    int   n_errors = 0;
`ifdef BP_STATS_EN
    logic [31:0] stat_lookups, stat_mispred;
`endif

    always #5 clk = ~clk;

    gshare_predictor_if #(.GHR_BITS(8)) bus();

    gshare_predictor #(
        .INDEX_BITS(10), .TAG_BITS(8), .COUNTER_BITS(2), .GHR_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
`ifdef BP_STATS_EN
        .stat_lookups_o(stat_lookups), .stat_mispred_o(stat_mispred),
`endif
        .init_done_o(init_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.pred_req_i = 1'b1;
        bus.pred_pc_i  = pc;
        @(posedge clk); #1;
        bus.pred_req_i = 1'b0;
    endtask

    task automatic check_pred(input string tag, input logic taken, input logic [7:0] ghr);
        check({tag, "_valid"}, 32'(bus.pred_valid_o), 32'd1);
        check({tag, "_taken"}, 32'(bus.pred_taken_o), 32'(taken));
        check({tag, "_ghr"},   32'(bus.pred_ghr_o),   32'(ghr));
    endtask

    task automatic update(input logic [31:0] pc, input logic [7:0] ghr, input logic taken,
                          input logic mis);
        bus.upd_valid_i      = 1'b1;
        bus.upd_pc_i         = pc;
        bus.upd_ghr_i        = ghr;
        bus.upd_taken_i      = taken;
        bus.upd_mispredict_i = mis;
        @(posedge clk); #1;
        bus.upd_valid_i      = 1'b0;
        bus.upd_mispredict_i = 1'b0;
    endtask

    // Repair through an unrelated PC (index 0x81) to put the GHR back at 0.
    task automatic force_ghr0();
        update(32'h204, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic wait_init(input string tag);
        int   cycles;
        logic seen_valid;
        cycles     = 0;
        seen_valid = 1'b0;
        bus.pred_req_i = 1'b1;
        bus.pred_pc_i  = 32'h100;
        while (!init_done && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.pred_valid_o) seen_valid = 1'b1;
            if (cycles == 500) check({tag, "_ready_in_init"}, 32'(bus.pred_ready_o), 32'd0);
        end
        bus.pred_req_i = 1'b0;
        check({tag, "_init_cycles"}, 32'(cycles), 32'd1024);
        check({tag, "_no_pred_in_init"}, 32'(seen_valid), 32'd0);
        check({tag, "_ready_run"}, 32'(bus.pred_ready_o), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.pred_valid_o), 32'd0);
        check({tag, "_taken"}, 32'(bus.pred_taken_o), 32'd0);
        check({tag, "_ghr"},   32'(bus.pred_ghr_o),   32'd0);
        check({tag, "_ready"}, 32'(bus.pred_ready_o), 32'd0);
        check({tag, "_done"},  32'(init_done),        32'd0);
    endtask

    initial begin
        bus.pred_req_i = 1'b0;  bus.pred_pc_i = '0;
        bus.upd_valid_i = 1'b0; bus.upd_pc_i = '0; bus.upd_ghr_i = '0;
        bus.upd_taken_i = 1'b0; bus.upd_mispredict_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        wait_init("init1");

        lookup(32'h100);
        check_pred("cold", 1'b0, 8'h00);
        @(posedge clk); #1;
        check("pulse_drop", 32'(bus.pred_valid_o), 32'd0);

        update(32'h100, 8'h00, 1'b1, 1'b0);
        lookup(32'h100);
        check_pred("alloc_wt", 1'b1, 8'h00);

        force_ghr0();
        update(32'h100, 8'h00, 1'b0, 1'b0);
        update(32'h100, 8'h00, 1'b0, 1'b0);
        lookup(32'h100);
        check_pred("dec_to0", 1'b0, 8'h00);
        update(32'h100, 8'h00, 1'b0, 1'b0);
        update(32'h100, 8'h00, 1'b1, 1'b0);
        lookup(32'h100);
        check_pred("floor_hold", 1'b0, 8'h00);
        update(32'h100, 8'h00, 1'b1, 1'b0);
        lookup(32'h100);
        check_pred("back_to_wt", 1'b1, 8'h00);

        force_ghr0();
        lookup(32'h1100);
        check_pred("tag_miss", 1'b0, 8'h00);

        repeat (4) update(32'h300, 8'h00, 1'b1, 1'b0);
        update(32'h300, 8'h00, 1'b0, 1'b0);
        lookup(32'h300);
        check_pred("sat_top", 1'b1, 8'h00);
        force_ghr0();
        update(32'h300, 8'h00, 1'b0, 1'b0);
        lookup(32'h300);
        check_pred("sat_dec", 1'b0, 8'h00);

        // pc 0 with history 0xC0 aliases the pc 0x300 entry.
        update(32'h000, 8'hC0, 1'b1, 1'b0);
        lookup(32'h300);
        check_pred("xor_update", 1'b1, 8'h00);
        update(32'h204, 8'h60, 1'b0, 1'b1);
        lookup(32'h000);
        check_pred("xor_lookup", 1'b1, 8'hC0);

        force_ghr0();
        bus.pred_req_i = 1'b1;        bus.pred_pc_i = 32'h300;
        bus.upd_valid_i = 1'b1;       bus.upd_pc_i = 32'h204;
        bus.upd_ghr_i = 8'h5A;        bus.upd_taken_i = 1'b1;
        bus.upd_mispredict_i = 1'b1;
        @(posedge clk); #1;
        bus.pred_req_i = 1'b0; bus.upd_valid_i = 1'b0; bus.upd_mispredict_i = 1'b0;
        check_pred("same_cycle_pred", 1'b1, 8'h00);
        lookup(32'h400);
        check("repair_wins_ghr", 32'(bus.pred_ghr_o), 32'hB5);

        force_ghr0();
        repeat (3) update(32'h500, 8'h00, 1'b1, 1'b0);
        lookup(32'h500);
        check_pred("trained", 1'b1, 8'h00);
        bus.pred_req_i = 1'b1;
        bus.pred_pc_i  = 32'h500;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        reset = 1'b0;
        wait_init("init2");
        lookup(32'h500);
        check_pred("after_reinit", 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
